// File: rtl/pattern_delay_timer_pkg.sv
// -----------------------------------------------------------------------------
// pattern_delay_timer_pkg
//
// Purpose : Shared definitions for the pattern_delay_timer block.
//           - Bit positions of each state inside the one-hot state vector
//             (state_oh bit order is {WAIT, COUNT, SHIFT, SEARCH}).
//           - tick_w(): width of the per-unit tick counter.
// -----------------------------------------------------------------------------
package pattern_delay_timer_pkg;

  // One-hot state bit positions.
  localparam int SEARCH     = 0;
  localparam int SHIFT      = 1;
  localparam int COUNT      = 2;
  localparam int WAIT       = 3;
  localparam int NUM_STATES = 4;

  // Width of a counter that runs 0..ticks-1. $clog2(1) is 0, so the width
  // is clamped to one bit to keep the register legal when ticks == 1.
  function automatic int tick_w(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : pattern_delay_timer_pkg

// File: rtl/pattern_delay_timer_matcher.sv
// -----------------------------------------------------------------------------
// serial_pattern_matcher
//
// Purpose : Watches a serial bit stream for a fixed start pattern. Keeps the
//           last PATTERN_W-1 bits plus a saturating count of how many of
//           those history bits are genuine (received since reset/clear).
//           match is asserted combinationally when the stored history
//           followed by the current bit d equals PATTERN and the history is
//           fully populated. Overlapping matches are naturally supported.
//
// Ports   :
//   clk    in  1  clock
//   reset  in  1  asynchronous active-high reset
//   clear  in  1  synchronous clear of history and valid count (wins over en)
//   en     in  1  shift d into the history this cycle
//   d      in  1  serial data bit
//   match  out 1  {history, d} == PATTERN with a fully valid history
// -----------------------------------------------------------------------------
module serial_pattern_matcher #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic match
);

  localparam int HIST_W = PATTERN_W - 1;
  // PATTERN_W >= 2, so this is at least one bit and can hold PATTERN_W-1.
  localparam int VCNT_W = $clog2(PATTERN_W);
  localparam logic [VCNT_W-1:0] VCNT_FULL = VCNT_W'(PATTERN_W - 1);

  logic [HIST_W-1:0] history_reg;
  logic [VCNT_W-1:0] valid_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history_reg   <= '0;
      valid_cnt_reg <= '0;
    end else if (clear) begin
      history_reg   <= '0;
      valid_cnt_reg <= '0;
    end else if (en) begin
      // Size cast drops the oldest bit, keeping the newest HIST_W bits.
      // Written this way so it also works when HIST_W == 1.
      history_reg <= HIST_W'({history_reg, d});
      if (valid_cnt_reg != VCNT_FULL) begin
        valid_cnt_reg <= valid_cnt_reg + VCNT_W'(1);
      end
    end
  end

  // The valid count guards against zeros left in history by reset/clear
  // forming a false match (e.g. PATTERN of all zeros).
  assign match = (valid_cnt_reg == VCNT_FULL) && ({history_reg, d} == PATTERN);

endmodule : serial_pattern_matcher

// File: rtl/pattern_delay_timer.sv
// -----------------------------------------------------------------------------
// pattern_delay_timer
//
// Purpose : Serial start-pattern -> delay shift -> timed count -> ack wait
//           controller. Searches d for PATTERN, shifts in a DELAY_W-bit delay
//           (MSB first), counts (delay+1)*TICKS cycles, then holds done until
//           the host acknowledges.
//
// Ports   :
//   clk        in  1        clock, rising edge
//   reset      in  1        asynchronous active-high reset
//   d          in  1        serial data (used in SEARCH and SHIFT)
//   ack        in  1        host acknowledge (used in WAIT only)
//   shift_ena  out 1        high while the delay bits are shifted in
//   counting   out 1        high in COUNT
//   done       out 1        high in WAIT
//   remaining  out DELAY_W  remaining delay units (meaningful in COUNT)
//   state_oh   out 4        one-hot state {WAIT, COUNT, SHIFT, SEARCH}
//
// All outputs are decoded directly from registers; d and ack only affect
// next-state logic.
// -----------------------------------------------------------------------------
module pattern_delay_timer
  import pattern_delay_timer_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   DELAY_W   = 4,
  parameter int                   TICKS     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               ack,
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] remaining,
  output logic [3:0]         state_oh
);

  localparam int TICK_W = tick_w(TICKS);
  localparam int SCNT_W = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS - 1);
  localparam logic [SCNT_W-1:0] SHIFT_LAST = SCNT_W'(DELAY_W - 1);

  localparam logic [NUM_STATES-1:0] ST_SEARCH = 4'(1 << SEARCH);
  localparam logic [NUM_STATES-1:0] ST_SHIFT  = 4'(1 << SHIFT);
  localparam logic [NUM_STATES-1:0] ST_COUNT  = 4'(1 << COUNT);
  localparam logic [NUM_STATES-1:0] ST_WAIT   = 4'(1 << WAIT);

  logic [NUM_STATES-1:0] state_reg,     state_next;
  logic [DELAY_W-1:0]    remaining_reg, remaining_next;
  logic [SCNT_W-1:0]     shift_cnt_reg, shift_cnt_next;
  logic [TICK_W-1:0]     tick_reg,      tick_next;

  logic                  match;
  logic                  matcher_en;
  logic                  matcher_clear;
  logic [DELAY_W-1:0]    shifted;

  // ---------------------------------------------------------------------------
  // Start-pattern detection. History only advances while searching, and is
  // wiped on the acknowledge cycle so a new command needs PATTERN_W fresh
  // bits (bits seen while waiting, or on the ack cycle itself, never count).
  // ---------------------------------------------------------------------------
  assign matcher_en    = state_reg[SEARCH];
  assign matcher_clear = state_reg[WAIT] & ack;

  serial_pattern_matcher #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN)
  ) u_matcher (
    .clk   (clk),
    .reset (reset),
    .clear (matcher_clear),
    .en    (matcher_en),
    .d     (d),
    .match (match)
  );

  // ---------------------------------------------------------------------------
  // MSB-first shift of the delay field into the remaining register.
  // ---------------------------------------------------------------------------
  generate
    if (DELAY_W == 1) begin : g_shift_narrow
      assign shifted = d;
    end else begin : g_shift_wide
      assign shifted = {remaining_reg[DELAY_W-2:0], d};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    shift_cnt_next = shift_cnt_reg;
    tick_next      = tick_reg;

    case (state_reg)
      ST_SEARCH: begin
        if (match) begin
          state_next     = ST_SHIFT;
          shift_cnt_next = '0;
        end
      end

      ST_SHIFT: begin
        remaining_next = shifted;
        if (shift_cnt_reg == SHIFT_LAST) begin
          state_next     = ST_COUNT;
          shift_cnt_next = '0;
          tick_next      = '0;
        end else begin
          shift_cnt_next = shift_cnt_reg + SCNT_W'(1);
        end
      end

      ST_COUNT: begin
        // Each delay unit lasts TICKS cycles; the unit in which remaining
        // reads 0 is still counted, giving (delay+1)*TICKS cycles in total.
        if (tick_reg == TICK_LAST) begin
          tick_next = '0;
          if (remaining_reg == '0) begin
            state_next = ST_WAIT;
          end else begin
            remaining_next = remaining_reg - DELAY_W'(1);
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end

      ST_WAIT: begin
        if (ack) begin
          state_next = ST_SEARCH;
        end
      end

      default: begin
        // Not reachable from legal operation; recover to a clean SEARCH.
        state_next     = ST_SEARCH;
        remaining_next = '0;
        shift_cnt_next = '0;
        tick_next      = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_SEARCH;
      remaining_reg <= '0;
      shift_cnt_reg <= '0;
      tick_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      shift_cnt_reg <= shift_cnt_next;
      tick_reg      <= tick_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state.
  // ---------------------------------------------------------------------------
  assign shift_ena = state_reg[SHIFT];
  assign counting  = state_reg[COUNT];
  assign done      = state_reg[WAIT];
  assign remaining = remaining_reg;
  assign state_oh  = state_reg;

endmodule : pattern_delay_timer
